// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, IMEM write port and CPU start/hold signals
// of the program loader. The host side is the master, the loader the slave.
interface imem_loader_if;
    logic        LD_start;
    logic        LD_byte_valid;
    logic [7:0]  LD_byte;
    logic        LD_byte_ready;
    logic        IM_wr_en;
    logic [31:0] IM_wr_addr;
    logic [31:0] IM_wr_data;
    logic        LD_cpu_hold;
    logic [31:0] LD_pc_val;
    logic        LD_done;
    logic        LD_error;

    modport master (
        output LD_start, LD_byte_valid, LD_byte,
        input  LD_byte_ready, IM_wr_en, IM_wr_addr, IM_wr_data,
               LD_cpu_hold, LD_pc_val, LD_done, LD_error
    );

    modport slave (
        input  LD_start, LD_byte_valid, LD_byte,
        output LD_byte_ready, IM_wr_en, IM_wr_addr, IM_wr_data,
               LD_cpu_hold, LD_pc_val, LD_done, LD_error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: write side of the instruction memory. Packs a big-endian host byte
// stream (base, count, words) into 32-bit IMEM writes while holding the CPU in reset.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic         SYS_clk,
    input  logic         SYS_reset,
    imem_loader_if.slave ld
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_ADDR = 3'd1,
        ST_HDR_CNT  = 3'd2,
        ST_DATA     = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  byte_cnt_r;
    logic [15:0] word_idx_r;
    logic [31:0] base_r;
    logic [15:0] count_r;
    logic [31:0] word_r;

    logic        ready_r, wr_en_r, hold_r, done_r, error_r;
    logic [31:0] wr_addr_r, wr_data_r, pc_val_r;
    logic        ready_s, wr_en_s, hold_s, done_s, error_s;
    logic [31:0] wr_addr_s, wr_data_s, pc_val_s;

    logic        session_idle_s;
    logic        start_ok_s;
    logic        accept_s;
    logic        last_byte_s;
    logic        last_word_s;
    logic        count_bad_s;
    logic [31:0] base_next_s;
    logic [15:0] count_next_s;
    logic [31:0] word_next_s;
    logic [32:0] span_s;

    assign session_idle_s = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR);
    assign start_ok_s     = ld.LD_start && session_idle_s;
    assign accept_s       = ld.LD_byte_valid && ready_r;
    assign base_next_s    = {base_r[23:0], ld.LD_byte};
    assign count_next_s   = {count_r[7:0], ld.LD_byte};
    assign word_next_s    = {word_r[23:0], ld.LD_byte};
    // Word span is summed in 33 bits so a large base cannot wrap below MAX_WORDS.
    assign span_s         = {3'b000, base_r[31:2]} + {17'd0, count_next_s};
    assign count_bad_s    = (count_next_s == 16'd0) || (span_s > 33'(MAX_WORDS));
    assign last_word_s    = (word_idx_r == (count_r - 16'd1));

    // Marks the final byte of the current header field or data word.
    always_comb begin
        last_byte_s = 1'b0;
        case (state_r)
            ST_HDR_ADDR: last_byte_s = (byte_cnt_r == 2'd3);
            ST_HDR_CNT:  last_byte_s = (byte_cnt_r == 2'd1);
            ST_DATA:     last_byte_s = (byte_cnt_r == 2'd3);
            default:     last_byte_s = 1'b0;
        endcase
    end

    // Next-state logic of the load session.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (ld.LD_start) next_state_s = ST_HDR_ADDR;
                else             next_state_s = state_r;
            end
            ST_HDR_ADDR: begin
                if (accept_s && last_byte_s) begin
                    if (base_next_s[1:0] != 2'b00) next_state_s = ST_ERROR;
                    else                           next_state_s = ST_HDR_CNT;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_HDR_CNT: begin
                if (accept_s && last_byte_s) begin
                    if (count_bad_s) next_state_s = ST_ERROR;
                    else             next_state_s = ST_DATA;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DATA: begin
                if (accept_s && last_byte_s) next_state_s = ST_WRITE;
                else                         next_state_s = state_r;
            end
            ST_WRITE: begin
                if (last_word_s) next_state_s = ST_DONE;
                else             next_state_s = ST_DATA;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs track the state register.
    always_comb begin
        ready_s   = 1'b0;
        wr_en_s   = 1'b0;
        hold_s    = 1'b1;
        done_s    = 1'b0;
        error_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        pc_val_s  = pc_val_r;
        case (next_state_s)
            ST_HDR_ADDR, ST_HDR_CNT, ST_DATA: ready_s = 1'b1;
            ST_WRITE: begin
                wr_en_s   = 1'b1;
                wr_addr_s = base_r + {14'd0, word_idx_r, 2'b00};
                wr_data_s = word_next_s;
            end
            ST_DONE: begin
                hold_s   = 1'b0;
                done_s   = 1'b1;
                pc_val_s = base_r;
            end
            ST_ERROR: error_s = 1'b1;
            default:  ready_s = 1'b0;
        endcase
    end

    // State register plus header/word datapath and session counters.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 2'd0;
            word_idx_r <= 16'd0;
            base_r     <= 32'd0;
            count_r    <= 16'd0;
            word_r     <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (start_ok_s) begin
                byte_cnt_r <= 2'd0;
                word_idx_r <= 16'd0;
            end else begin
                if (accept_s) byte_cnt_r <= last_byte_s ? 2'd0 : byte_cnt_r + 2'd1;
                if (state_r == ST_WRITE) word_idx_r <= word_idx_r + 16'd1;
            end
            if (accept_s) begin
                case (state_r)
                    ST_HDR_ADDR: base_r  <= base_next_s;
                    ST_HDR_CNT:  count_r <= count_next_s;
                    ST_DATA:     word_r  <= word_next_s;
                    default:     word_r  <= word_r;
                endcase
            end
        end
    end

    // Output registers.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            ready_r   <= 1'b0;
            wr_en_r   <= 1'b0;
            hold_r    <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            wr_addr_r <= 32'd0;
            wr_data_r <= 32'd0;
            pc_val_r  <= 32'd0;
        end else begin
            ready_r   <= ready_s;
            wr_en_r   <= wr_en_s;
            hold_r    <= hold_s;
            done_r    <= done_s;
            error_r   <= error_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            pc_val_r  <= pc_val_s;
        end
    end

    assign ld.LD_byte_ready = ready_r;
    assign ld.IM_wr_en      = wr_en_r;
    assign ld.IM_wr_addr    = wr_addr_r;
    assign ld.IM_wr_data    = wr_data_r;
    assign ld.LD_cpu_hold   = hold_r;
    assign ld.LD_pc_val     = pc_val_r;
    assign ld.LD_done       = done_r;
    assign ld.LD_error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized load sessions against a reference model
// of the loader's header rules, write addresses and session timing.
module tb_imem_loader;
    localparam int MAX_WORDS = 256;

    logic SYS_clk;
    logic SYS_reset;
    imem_loader_if ld_if ();

    imem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .ld        (ld_if)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int b2b_cnt = 0;
    bit prev_wr = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] words_q[$];

    always @(posedge SYS_clk) cyc <= cyc + 1;

    // Write-strobe monitor: logs every IMEM write with the cycle it appeared in.
    always @(negedge SYS_clk) begin
        if (ld_if.IM_wr_en === 1'b1) begin
            wr_addr_q.push_back(ld_if.IM_wr_addr);
            wr_data_q.push_back(ld_if.IM_wr_data);
            wr_cyc_q.push_back(cyc);
            if (prev_wr) b2b_cnt <= b2b_cnt + 1;
        end
        prev_wr <= (ld_if.IM_wr_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] v, input int k);
        return v[8*k +: 8];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ld_if.LD_byte_ready, 32'd0);
        chk({tag, "_wr_en"}, ld_if.IM_wr_en, 32'd0);
        chk({tag, "_wr_addr"}, ld_if.IM_wr_addr, 32'd0);
        chk({tag, "_wr_data"}, ld_if.IM_wr_data, 32'd0);
        chk({tag, "_hold"}, ld_if.LD_cpu_hold, 32'd1);
        chk({tag, "_pc_val"}, ld_if.LD_pc_val, 32'd0);
        chk({tag, "_done"}, ld_if.LD_done, 32'd0);
        chk({tag, "_error"}, ld_if.LD_error, 32'd0);
    endtask

    task automatic pulse_start();
        ld_if.LD_start = 1'b1;
        step();
        ld_if.LD_start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles and holds it until accepted.
    task automatic send_byte(input string tag, input logic [7:0] b, input int gap, output int acc_cyc);
        int budget;
        repeat (gap) step();
        ld_if.LD_byte       = b;
        ld_if.LD_byte_valid = 1'b1;
        budget = 0;
        @(negedge SYS_clk);
        while (ld_if.LD_byte_ready !== 1'b1 && budget < 40) begin
            @(negedge SYS_clk);
            budget++;
        end
        chk({tag, "_ready_for_byte"}, ld_if.LD_byte_ready, 32'd1);
        step();
        acc_cyc = cyc;
        ld_if.LD_byte_valid = 1'b0;
        ld_if.LD_byte       = 8'h00;
    endtask

    task automatic send_header(input string tag, input logic [31:0] base, input logic [15:0] n,
                               input int gmin, input int gmax, input bit with_count);
        int acc;
        for (int j = 0; j < 4; j++) send_byte(tag, byte_of(base, 3 - j), $urandom_range(gmax, gmin), acc);
        if (with_count) begin
            send_byte(tag, n[15:8], $urandom_range(gmax, gmin), acc);
            send_byte(tag, n[7:0], $urandom_range(gmax, gmin), acc);
        end
    endtask

    task automatic check_error(input string tag, input int wr0);
        chk({tag, "_error"}, ld_if.LD_error, 32'd1);
        chk({tag, "_err_ready"}, ld_if.LD_byte_ready, 32'd0);
        chk({tag, "_err_hold"}, ld_if.LD_cpu_hold, 32'd1);
        chk({tag, "_err_done"}, ld_if.LD_done, 32'd0);
        ld_if.LD_byte       = 8'hA5;
        ld_if.LD_byte_valid = 1'b1;
        repeat (4) step();
        chk({tag, "_err_still_ready"}, ld_if.LD_byte_ready, 32'd0);
        chk({tag, "_err_sticky"}, ld_if.LD_error, 32'd1);
        chk({tag, "_err_no_writes"}, wr_addr_q.size() - wr0, 32'd0);
        ld_if.LD_byte_valid = 1'b0;
        ld_if.LD_byte       = 8'h00;
    endtask

    // One full session; outcome and writes are predicted from the header rules.
    task automatic run_load(input string tag, input logic [31:0] base, input int n,
                            input int gmin, input int gmax, input bit best, input bit inject);
        bit addr_bad, cnt_bad;
        int wr0, b2b0, acc, s_cyc, d_cyc, budget, got;
        int acc_q[$];
        addr_bad = (base % 32'd4) != 32'd0;
        cnt_bad  = (n == 0) || ((longint'(base / 32'd4) + longint'(n)) > longint'(MAX_WORDS));
        wr0  = wr_addr_q.size();
        b2b0 = b2b_cnt;
        pulse_start();
        s_cyc = cyc;
        chk({tag, "_start_hold"}, ld_if.LD_cpu_hold, 32'd1);
        chk({tag, "_start_ready"}, ld_if.LD_byte_ready, 32'd1);
        chk({tag, "_start_done"}, ld_if.LD_done, 32'd0);
        chk({tag, "_start_error"}, ld_if.LD_error, 32'd0);
        send_header(tag, base, 16'(n), gmin, gmax, 1'b0);
        if (addr_bad) begin
            check_error({tag, "_addr"}, wr0);
            return;
        end
        send_byte(tag, byte_of(32'(n), 1), $urandom_range(gmax, gmin), acc);
        send_byte(tag, byte_of(32'(n), 0), $urandom_range(gmax, gmin), acc);
        if (cnt_bad) begin
            check_error({tag, "_cnt"}, wr0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(tag, byte_of(words_q[i], 3 - j), $urandom_range(gmax, gmin), acc);
                if (inject && i == 0 && j == 1) pulse_start();
            end
            acc_q.push_back(acc);
        end
        budget = 0;
        @(negedge SYS_clk);
        while (ld_if.LD_done !== 1'b1 && budget < 30) begin
            @(negedge SYS_clk);
            budget++;
        end
        d_cyc = cyc;
        chk({tag, "_done"}, ld_if.LD_done, 32'd1);
        chk({tag, "_hold_released"}, ld_if.LD_cpu_hold, 32'd0);
        chk({tag, "_pc_val"}, ld_if.LD_pc_val, base);
        chk({tag, "_no_error"}, ld_if.LD_error, 32'd0);
        chk({tag, "_done_ready"}, ld_if.LD_byte_ready, 32'd0);
        chk({tag, "_done_after_strobe"}, d_cyc, acc_q[n-1] + 1);
        if (best) chk({tag, "_session_cycles"}, d_cyc - s_cyc, 32'(6 + 5 * n));
        got = wr_addr_q.size() - wr0;
        chk({tag, "_wr_count"}, got, n);
        for (int i = 0; i < n && i < got; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[wr0 + i], base + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[wr0 + i], words_q[i]);
            chk($sformatf("%s_lat%0d", tag, i), wr_cyc_q[wr0 + i], acc_q[i]);
        end
        chk({tag, "_b2b_strobe"}, b2b_cnt - b2b0, 32'd0);
        step();
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    initial begin
        int kind, b4, n, wr0, acc;
        logic [31:0] base;
        SYS_reset           = 1'b1;
        ld_if.LD_start      = 1'b0;
        ld_if.LD_byte_valid = 1'b0;
        ld_if.LD_byte       = 8'h00;
        repeat (3) step();
        check_reset_outputs("reset");
        SYS_reset = 1'b0;
        step();

        words_q = '{32'h8C010004, 32'hAC020008};
        run_load("basic", 32'h0000_0000, 2, 0, 0, 1'b1, 1'b0);

        words_q = '{32'h2001_0005};
        run_load("valid_toggle", 32'h0000_0100, 1, 1, 1, 1'b0, 1'b0);

        run_load("misaligned", 32'h0000_0002, 1, 0, 0, 1'b0, 1'b0);

        fill_random(2);
        run_load("over_max", 32'h0000_03FC, 2, 0, 1, 1'b0, 1'b0);
        words_q = '{32'hDEAD_BEEF};
        run_load("at_max", 32'h0000_03FC, 1, 0, 0, 1'b1, 1'b0);

        run_load("n_zero", 32'h0000_0040, 0, 0, 0, 1'b0, 1'b0);
        fill_random(1);
        run_load("after_err", 32'h0000_0010, 1, 0, 2, 1'b0, 1'b0);

        fill_random(3);
        run_load("start_ignored", 32'h0000_0020, 3, 0, 1, 1'b0, 1'b1);

        // Reset while the first of three data words is half received.
        wr0 = wr_addr_q.size();
        pulse_start();
        send_header("mid_reset", 32'h0000_0040, 16'd3, 0, 0, 1'b1);
        send_byte("mid_reset", 8'h11, 0, acc);
        send_byte("mid_reset", 8'h22, 0, acc);
        SYS_reset = 1'b1;
        step();
        SYS_reset = 1'b0;
        check_reset_outputs("mid_reset");
        ld_if.LD_byte_valid = 1'b1;
        repeat (3) step();
        chk("mid_reset_idle_ready", ld_if.LD_byte_ready, 32'd0);
        chk("mid_reset_no_writes", wr_addr_q.size() - wr0, 32'd0);
        ld_if.LD_byte_valid = 1'b0;
        step();
        fill_random(3);
        run_load("post_reset", 32'h0000_0080, 3, 0, 0, 1'b1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            kind = $urandom_range(3, 0);
            b4   = $urandom_range(255, 0);
            if (kind <= 1) begin
                n    = $urandom_range(((256 - b4) < 6) ? (256 - b4) : 6, 1);
                base = 32'(b4 * 4);
            end else if (kind == 2) begin
                n    = $urandom_range(4, 1);
                base = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1));
            end else begin
                n    = 256 - b4 + $urandom_range(3000, 1);
                base = 32'(b4 * 4);
            end
            fill_random((n <= 256) ? n : 0);
            run_load($sformatf("rand%0d", r), base, n, 0, 2, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
